// File: rtl/atconv_pool_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : atconv_pool_engine_if
// Brief    : Handshake, image-read and feature-memory bus of the atrous-conv /
//            max-pool engine.
// Revision : 1.0
// ============================================================================
interface atconv_pool_engine_if #(
    parameter int LOG2_W = 6,
    parameter int DW     = 13
);
    logic                  ready;
    logic [1:0]            round_mode;
    logic                  busy;
    logic [2*LOG2_W-1:0]   iaddr;
    logic [DW-1:0]         idata;
    logic                  cwr;
    logic [2*LOG2_W-1:0]   caddr_wr;
    logic [DW-1:0]         cdata_wr;
    logic                  crd;
    logic [2*LOG2_W-1:0]   caddr_rd;
    logic [DW-1:0]         cdata_rd;
    logic                  csel;

    // Engine side drives addresses and strobes.
    modport master (
        input  ready, round_mode, idata, cdata_rd,
        output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );

    modport slave (
        output ready, round_mode, idata, cdata_rd,
        input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );
endinterface
`default_nettype wire

// File: rtl/atconv_pool_engine.sv
`default_nettype none
// ============================================================================
// Module   : atconv_pool_engine
// Brief    : 3x3 dilated conv (clamp padding, bias, ReLU) into bank 0, then
//            2x2/2 max-pool with run-time rounding into bank 1.
//            ATCONV_POOL_SAT_EN: saturate positive layer-0 overflow.
// Revision : 1.0
// ============================================================================
module atconv_pool_engine #(
    parameter int               LOG2_W = 6,
    parameter int               DW     = 13,
    parameter int               FRAC   = 4,
    parameter int               DIL    = 2,
    parameter logic [9*DW-1:0]  KERNEL = {13'h1FFF, 13'h1FFE, 13'h1FFF,
                                          13'h1FFC, 13'h0010, 13'h1FFC,
                                          13'h1FFF, 13'h1FFE, 13'h1FFF},
    parameter logic [DW-1:0]    BIAS   = 13'h1FF4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    atconv_pool_engine_if.master    bus
);
    localparam int AW   = 2 * LOG2_W;
    localparam int PW   = LOG2_W - 1;
    localparam int ACCW = 2 * DW + 4;
    localparam int NPIX = 1 << AW;
    localparam logic [AW-1:0]          C_LAST_PIX  = AW'(NPIX - 1);
    localparam logic [AW-1:0]          C_LAST_POOL = AW'(NPIX / 4 - 1);
    localparam logic signed [PW+2:0]   C_DIL       = (PW + 3)'(DIL);
    localparam logic signed [PW+2:0]   C_MAXC      = (PW + 3)'((1 << LOG2_W) - 1);
    localparam logic signed [ACCW-1:0] C_ACC_INIT  =
        $signed({{(ACCW - DW){BIAS[DW-1]}}, BIAS}) <<< FRAC;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONV_RD = 3'd1,
        S_CONV_WR = 3'd2,
        S_POOL_RD = 3'd3,
        S_POOL_WR = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             tap_q, tap_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [DW-1:0]          max_q, max_d;
    logic [1:0]             mode_q, mode_d;
    logic                   busy_q, busy_d;

    logic [1:0]             w_row_sel, w_col_sel;
    logic signed [DW-1:0]   w_coef;
    logic signed [2*DW-1:0] w_prod;
    logic                   w_sat, w_inc;
    logic [DW-1:0]          w_conv_out, w_pool_out;
    logic [DW-FRAC-1:0]     w_int;

    // Tap offset selector: 0 = -DIL, 1 = 0, 2 = +DIL.
    function automatic logic [LOG2_W-1:0] clamp_coord(input logic [LOG2_W-1:0] base,
                                                      input logic [1:0] sel);
        logic signed [PW+2:0] v;
        v = $signed({2'b00, base});
        if (sel == 2'd0)      v = v - C_DIL;
        else if (sel == 2'd2) v = v + C_DIL;
        if (v[PW+2])          return '0;
        else if (v > C_MAXC)  return '1;
        else                  return v[LOG2_W-1:0];
    endfunction

    always_comb begin
        w_row_sel = 2'd2;
        if (tap_q < 4'd3)      w_row_sel = 2'd0;
        else if (tap_q < 4'd6) w_row_sel = 2'd1;
        w_col_sel = 2'd2;
        if (tap_q == 4'd0 || tap_q == 4'd3 || tap_q == 4'd6)      w_col_sel = 2'd0;
        else if (tap_q == 4'd1 || tap_q == 4'd4 || tap_q == 4'd7) w_col_sel = 2'd1;
    end

    // Data for tap t-1 arrives while tap t is being addressed.
    always_comb begin
        w_coef = '0;
        for (int i = 0; i < 9; i++)
            if (tap_q == 4'(i + 1)) w_coef = KERNEL[i*DW +: DW];
    end
    assign w_prod = $signed(bus.idata) * w_coef;

`ifdef ATCONV_POOL_SAT_EN
    assign w_sat = |acc_q[ACCW-2:DW+FRAC-1];
`else
    assign w_sat = 1'b0;
`endif

    always_comb begin
        if (acc_q[ACCW-1]) w_conv_out = '0;
        else if (w_sat)    w_conv_out = {1'b0, {(DW - 1){1'b1}}};
        else               w_conv_out = DW'(acc_q >>> FRAC);
    end

    always_comb begin
        case (mode_q)
            2'd0:    w_inc = |max_q[FRAC-1:0];
            2'd2:    w_inc = max_q[FRAC-1];
            default: w_inc = 1'b0;
        endcase
        w_int      = max_q[DW-1:FRAC] + (DW - FRAC)'(w_inc);
        w_pool_out = (mode_q == 2'd3) ? max_q : {w_int, {FRAC{1'b0}}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tap_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            max_q   <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        max_d        = max_q;
        mode_d       = mode_q;
        busy_d       = busy_q;
        bus.iaddr    = '0;
        bus.cwr      = 1'b0;
        bus.caddr_wr = '0;
        bus.cdata_wr = '0;
        bus.crd      = 1'b0;
        bus.caddr_rd = '0;
        bus.csel     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ready) begin
                    busy_d  = 1'b1;
                    mode_d  = bus.round_mode;
                    idx_d   = '0;
                    tap_d   = '0;
                    acc_d   = C_ACC_INIT;
                    state_d = S_CONV_RD;
                end
            end
            S_CONV_RD: begin
                if (tap_q < 4'd9)
                    bus.iaddr = {clamp_coord(idx_q[AW-1:LOG2_W], w_row_sel),
                                 clamp_coord(idx_q[LOG2_W-1:0], w_col_sel)};
                if (tap_q != 4'd0)
                    acc_d = acc_q + {{(ACCW - 2*DW){w_prod[2*DW-1]}}, w_prod};
                if (tap_q == 4'd9) begin
                    tap_d   = '0;
                    state_d = S_CONV_WR;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_CONV_WR: begin
                bus.cwr      = 1'b1;
                bus.caddr_wr = idx_q;
                bus.cdata_wr = w_conv_out;
                acc_d        = C_ACC_INIT;
                idx_d        = idx_q + 1'b1;
                state_d      = (idx_q == C_LAST_PIX) ? S_POOL_RD : S_CONV_RD;
            end
            S_POOL_RD: begin
                bus.crd      = 1'b1;
                bus.caddr_rd = {idx_q[2*PW-1:PW], tap_q[1], idx_q[PW-1:0], tap_q[0]};
                if (tap_q == 4'd0)             max_d = '0;
                else if (bus.cdata_rd > max_q) max_d = bus.cdata_rd;
                if (tap_q == 4'd4) begin
                    tap_d   = '0;
                    state_d = S_POOL_WR;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            S_POOL_WR: begin
                bus.cwr      = 1'b1;
                bus.csel     = 1'b1;
                bus.caddr_wr = idx_q;
                bus.cdata_wr = w_pool_out;
                if (idx_q == C_LAST_POOL) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_POOL_RD;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_atconv_pool_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_atconv_pool_engine
// Brief    : Scoreboard bench: arithmetic reference of conv + pool, monitor
//            compares every memory write the engine issues.
// Revision : 1.0
// ============================================================================
module tb_atconv_pool_engine;
    localparam int LOG2_W      = 3;
    localparam int DW          = 13;
    localparam int AW          = 2 * LOG2_W;
    localparam int W           = 1 << LOG2_W;
    localparam int N           = W * W;
    localparam int NP          = N / 4;
    localparam int DIL         = 2;
    localparam int BIAS_V      = -12;
    localparam int BUSY_CYCLES = N * 11 + (N / 4) * 6 + 1;

    typedef struct packed {
        logic          sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    atconv_pool_engine_if #(.LOG2_W(LOG2_W), .DW(DW)) bus ();
    atconv_pool_engine #(.LOG2_W(LOG2_W), .DW(DW), .DIL(DIL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] img   [N];
    logic [DW-1:0] bank0 [N];
    logic [DW-1:0] bank1 [NP];
    int            kern  [9] = '{-1, -2, -1, -4, 16, -4, -1, -2, -1};
    wr_t           exp_q [$];
    wr_t           mon_exp;
    int            n_checks = 0;
    int            n_errors = 0;

    // Synchronous-read memories around the engine.
    always @(posedge clk) begin
        bus.idata    <= img[bus.iaddr];
        bus.cdata_rd <= bank0[bus.caddr_rd];
        if (bus.cwr && !bus.csel) bank0[bus.caddr_wr] <= bus.cdata_wr;
        if (bus.cwr && bus.csel)  bank1[bus.caddr_wr[AW-3:0]] <= bus.cdata_wr;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return v[DW-1] ? int'(v) - (1 << DW) : int'(v);
    endfunction

    function automatic int clampi(input int x);
        return (x < 0) ? 0 : ((x > W - 1) ? W - 1 : x);
    endfunction

    function automatic int conv_ref(input int r, input int c);
        int acc;
        int v;
        acc = BIAS_V * 16;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
                acc += sx(img[clampi(r + (ky - 1) * DIL) * W + clampi(c + (kx - 1) * DIL)])
                       * kern[ky * 3 + kx];
        if (acc < 0) return 0;
        v = acc / 16;
`ifdef ATCONV_POOL_SAT_EN
        if (v > 4095) v = 4095;
`endif
        return v % 8192;
    endfunction

    function automatic int round_ref(input int m, input logic [1:0] mode);
        int r;
        case (mode)
            2'd0:    r = ((m + 15) / 16) * 16;
            2'd1:    r = (m / 16) * 16;
            2'd2:    r = ((m + 8) / 16) * 16;
            default: r = m;
        endcase
        return r % 8192;
    endfunction

    task automatic push_expect(input logic [1:0] mode);
        int l0 [N];
        int m;
        for (int p = 0; p < N; p++) begin
            l0[p] = conv_ref(p / W, p % W);
            exp_q.push_back('{sel: 1'b0, addr: AW'(p), data: DW'(l0[p])});
        end
        for (int q = 0; q < NP; q++) begin
            m = 0;
            for (int d = 0; d < 4; d++)
                m = (l0[(2 * (q / (W / 2)) + d / 2) * W + 2 * (q % (W / 2)) + d % 2] > m) ?
                    l0[(2 * (q / (W / 2)) + d / 2) * W + 2 * (q % (W / 2)) + d % 2] : m;
            exp_q.push_back('{sel: 1'b1, addr: AW'(q), data: DW'(round_ref(m, mode))});
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.cwr) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got sel=%0d addr=%0d data=%0h, expected none",
                         bus.csel, bus.caddr_wr, bus.cdata_wr);
            end else begin
                mon_exp = exp_q.pop_front();
                chk($sformatf("write sel%0d addr%0d {sel,addr,data}", mon_exp.sel, mon_exp.addr),
                    {bus.csel, bus.caddr_wr, bus.cdata_wr}, mon_exp);
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},     bus.busy,     0);
        chk({tag, "_cwr"},      bus.cwr,      0);
        chk({tag, "_crd"},      bus.crd,      0);
        chk({tag, "_csel"},     bus.csel,     0);
        chk({tag, "_iaddr"},    bus.iaddr,    0);
        chk({tag, "_caddr_wr"}, bus.caddr_wr, 0);
        chk({tag, "_caddr_rd"}, bus.caddr_rd, 0);
        chk({tag, "_cdata_wr"}, bus.cdata_wr, 0);
    endtask

    // Called at a negedge with the engine idle; returns at the first idle negedge.
    task automatic run(input logic [1:0] mode, input string tag);
        int cyc;
        push_expect(mode);
        bus.round_mode = mode;
        bus.ready      = 1'b1;
        @(posedge clk);
        #1 bus.ready = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy || cyc > BUSY_CYCLES + 100) break;
            cyc++;
            if (cyc == 50) begin
                bus.ready      = 1'b1;
                bus.round_mode = ~mode;
            end else if (cyc == 52) begin
                bus.ready      = 1'b0;
                bus.round_mode = mode;
            end
        end
        chk({tag, "_busy_cycles"}, cyc, BUSY_CYCLES);
        chk({tag, "_writes_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic fill_img(input int lo, input int hi);
        for (int p = 0; p < N; p++) img[p] = DW'($urandom_range(hi, lo));
    endtask

    task automatic clear_img();
        for (int p = 0; p < N; p++) img[p] = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.ready      = 1'b0;
        bus.round_mode = 2'd0;
        clear_img();
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        for (int p = 0; p < N; p++) img[p] = 13'h0010;
        run(2'd0, "ones");
        chk("ones_l1_addr0", bank1[0], 0);

        clear_img();
        img[3 * W + 3] = 13'h0010;
        run(2'd0, "imp_ceil");
        chk("imp_l0_addr27", bank0[27], 13'h004);
        chk("imp_ceil_l1_addr5", bank1[5], 13'h010);
        run(2'd1, "imp_floor");
        chk("imp_floor_l1_addr5", bank1[5], 13'h000);
        run(2'd2, "imp_near");
        chk("imp_near_l1_addr5", bank1[5], 13'h000);

        clear_img();
        img[0] = 13'h0100;
        run(2'd0, "corner");
        chk("corner_l0_addr0", bank0[0], 13'h084);
        chk("corner_l0_addr9", bank0[9], 13'h000);
        chk("corner_l1_addr0", bank1[0], 13'h090);

        fill_img(0, 255);
        run(2'(($urandom_range(3, 0))), "rand_small");
        fill_img(0, 8191);
        run(2'd2, "rand_full");

        clear_img();
        img[3 * W + 3] = 13'h0FFF;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (dy != 0 || dx != 0) img[(3 + dy * DIL) * W + 3 + dx * DIL] = 13'h1000;
        run(2'd3, "sat");
`ifdef ATCONV_POOL_SAT_EN
        chk("sat_l0_addr27", bank0[27], 13'h0FFF);
`else
        chk("sat_l0_addr27", bank0[27], 13'h1FF3);
`endif

        fill_img(0, 1023);
        push_expect(2'd0);
        bus.round_mode = 2'd0;
        bus.ready      = 1'b1;
        @(posedge clk);
        #1 bus.ready = 1'b0;
        for (cyc = 0; cyc < 300; cyc++) @(negedge clk);
        chk("midrun_busy_before_reset", bus.busy, 1);
        #2 reset = 1'b0;
        #1 chk_zero_outputs("midrun_reset");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run(2'd0, "after_reset");

        fill_img(0, 2047);
        run(2'd1, "b2b_first");
        fill_img(0, 2047);
        run(2'd3, "b2b_second");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
